serial_normalizer: RTL and testbench
====================================

Name: serial_normalizer

Overview:
Multi-cycle front end of the two's-complement-to-floating-point converter. It sits directly upstream of `rounder`. It accepts a 12-bit two's-complement sample, forms sign and magnitude, and normalizes the magnitude with a one-bit-per-cycle left shifter. It then presents S, a 3-bit exponent, a 5-bit significand and the Sixth (round) bit to the rounder under a valid/ready handshake.

Parameters:
None. Widths are fixed: 12-bit input, 3-bit E, 5-bit F, matching the `rounder` interface.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous, active-low reset
D  input  12  two's-complement sample
in_valid  input  1  D valid
in_ready  output  1  block can accept D
out_ready  input  1  downstream (rounder/result register) accepts result
out_valid  output  1  S/E/F/Sixth valid
S  output  1  sign bit (D[11] of accepted sample)
E  output  3  exponent, feeds rounder E_in
F  output  5  significand, feeds rounder F_in
Sixth  output  1  first bit below F, feeds rounder Sixth

Behaviour:
- One clock, clk. Reset is synchronous, active-low (reset_n sampled on rising clk edge).
- Reset (reset_n=0 at clk edge):
  - state=IDLE, out_valid=0, S/E/F/Sixth=0, shift register=0, count=0.
  - in_ready=0 while reset_n=0.
- States: IDLE -> ABS -> SHIFT -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register D and go to ABS (accept cycle = cycle 0).
  - in_valid without handshake is ignored.
- ABS (cycle 1):
  - S<=D[11].
  - mag<=D[11] ? (~D+1) : D, 12-bit unsigned. D=12'h800 gives mag=12'h800 (no overflow handling needed).
  - count<=0. Go to SHIFT.
- SHIFT, evaluated each cycle:
  - If mag_sh[11]==1 or count==7, go to DONE.
  - Else mag_sh<=mag_sh<<1, count<=count+1.
  - At most 7 shifts.
- DONE:
  - out_valid=1.
  - E=7-count. F=mag_sh[11:7]. Sixth=mag_sh[6].
  - Zero-fill on shift, so count==7 gives E=0, F=mag[4:0], Sixth=0.
  - Outputs are registered and held stable while out_valid&!out_ready.
  - On out_valid&out_ready, go to IDLE next cycle. out_valid=0 that cycle.
- in_ready=0 in ABS, SHIFT and DONE. No overlap between samples.
- Latency: out_valid first high in cycle 3+min(lz,7), where lz = leading zeros of the 12-bit mag.
  - Min 3 (lz=0), max 10 (lz>=7, including zero).
- Equivalence to the combinational mapping:
  - lz<7: E=7-lz, F=mag[11-lz:7-lz], Sixth=mag[6-lz].
  - lz>=7: E=0, F=mag[4:0], Sixth=0.
- No rounding, saturation or sticky bit here. The rounder owns F=11111/Sixth=1 overflow.
- Reset mid-operation (any state): abort immediately, outputs cleared next edge, partial result discarded.
- Simultaneous in_valid while not IDLE: ignored, not queued.
- out_ready ignored when out_valid=0.

Test Plan:
- Reset, then D=12'h000, out_ready=1 -> out_valid at cycle 10; S=0, E=000, F=00000, Sixth=0; one-cycle valid pulse; in_ready high again the following cycle.
- D=12'h800 (-2048) -> out_valid at cycle 3; S=1, E=111, F=10000, Sixth=0.
- D=12'd127 -> out_valid at cycle 8; S=0, E=010, F=11111, Sixth=1 (rounder overflow input); D=12'h7FF -> cycle 4, S=0, E=110, F=11111, Sixth=1.
- D=12'hFFF (-1) -> out_valid at cycle 10; S=1, E=000, F=00001, Sixth=0; D=12'd422 -> cycle 6, S=0, E=100, F=11010, Sixth=0.
- Backpressure: D=12'd422 with out_ready=0 for 5 cycles after out_valid -> S/E/F/Sixth/out_valid stable, in_ready=0, extra in_valid pulses with D=12'h123 ignored; raise out_ready -> single transfer, then IDLE.
- Reset mid-SHIFT: D=12'h001 accepted, reset_n=0 at cycle 5 for one edge -> next cycle out_valid=0, E/F/S/Sixth=0; after release in_ready=1, new D=12'h7FF yields correct result at cycle 4 after accept.

Source files
------------

// File: rtl/serial_normalizer.sv
// Front end of the two's-complement to floating-point converter: takes a 12-bit
// sample, forms sign/magnitude and normalizes it one bit per clock for the rounder.
module serial_normalizer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] D,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        S,
    output logic [2:0]  E,
    output logic [4:0]  F,
    output logic        Sixth
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABS   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] d_q;
    logic [11:0] mag_sh;
    logic [2:0]  count;
    logic        shift_done;

    // Normalization stops at a leading one or after the seventh shift.
    assign shift_done = mag_sh[11] || (count == 3'd7);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: a default assignment before the case keeps this block free of
    // inferred latches on paths that do not change state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid)  state_nxt = ABS;
            ABS:                  state_nxt = SHIFT;
            SHIFT: if (shift_done) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = reset_n && (state == IDLE);
        out_valid = (state == DONE);
    end

    // NOTE: every datapath register is reset, not just the control state, so a
    // reset mid-operation leaves no partial result visible on the outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d_q    <= '0;
            mag_sh <= '0;
            count  <= '0;
            S      <= 1'b0;
            E      <= '0;
            F      <= '0;
            Sixth  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) d_q <= D;
                end
                ABS: begin
                    // 12'h800 negates to itself, which is the correct magnitude.
                    S      <= d_q[11];
                    mag_sh <= d_q[11] ? (~d_q + 12'd1) : d_q;
                    count  <= '0;
                end
                SHIFT: begin
                    if (shift_done) begin
                        E     <= 3'd7 - count;
                        F     <= mag_sh[11:7];
                        Sixth <= mag_sh[6];
                    end else begin
                        mag_sh <= mag_sh << 1;
                        count  <= count + 3'd1;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_normalizer.sv
// Directed bench for serial_normalizer: literal expectations per vector plus a
// sign/magnitude/leading-zero reference model checked by a cycle monitor.
module tb_serial_normalizer;

    logic        clk;
    logic        reset_n;
    logic [11:0] D;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic        S;
    logic [2:0]  E;
    logic [4:0]  F;
    logic        Sixth;

    typedef struct {
        int s;
        int e;
        int f;
        int sixth;
        int lat;
    } res_t;

    typedef struct {
        logic [11:0] d;
        int          s;
        int          e;
        int          f;
        int          sixth;
        int          lat;
    } vec_t;

    int   cmp_n = 0;
    int   bad_n = 0;
    res_t exp_q[$];

    serial_normalizer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .D         (D),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .S         (S),
        .E         (E),
        .F         (F),
        .Sixth     (Sixth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        cmp_n++;
        if (act != exp) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: signed value -> magnitude -> leading zeros -> field extraction.
    function automatic res_t model(input logic [11:0] d);
        res_t r;
        int   v;
        int   mag;
        int   bits;
        int   lz;
        v   = d[11] ? int'(d) - 4096 : int'(d);
        mag = (v < 0) ? -v : v;
        bits = 0;
        while ((mag >> bits) != 0) bits++;
        lz = 12 - bits;
        r.s = (v < 0) ? 1 : 0;
        if (lz < 7) begin
            r.e     = 7 - lz;
            r.f     = (mag >> (7 - lz)) & 31;
            r.sixth = (mag >> (6 - lz)) & 1;
        end else begin
            r.e     = 0;
            r.f     = mag & 31;
            r.sixth = 0;
        end
        r.lat = 3 + ((lz < 7) ? lz : 7);
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("mon_spurious_valid", int'(out_valid), 0);
            end else begin
                check("mon_S", int'(S), exp_q[0].s);
                check("mon_E", int'(E), exp_q[0].e);
                check("mon_F", int'(F), exp_q[0].f);
                check("mon_Sixth", int'(Sixth), exp_q[0].sixth);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input vec_t v, input string name);
        int cyc;
        exp_q.push_back(model(v.d));
        @(posedge clk); #1;
        D        = v.d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, cyc, v.lat);
        check({name, "_S"}, int'(S), v.s);
        check({name, "_E"}, int'(E), v.e);
        check({name, "_F"}, int'(F), v.f);
        check({name, "_Sixth"}, int'(Sixth), v.sixth);
    endtask

    vec_t vecs[10] = '{
        '{12'h000, 0, 0, 0,  0, 10},
        '{12'h800, 1, 7, 16, 0, 3},
        '{12'd127, 0, 2, 31, 1, 8},
        '{12'h7FF, 0, 6, 31, 1, 4},
        '{12'hFFF, 1, 0, 1,  0, 10},
        '{12'd422, 0, 4, 26, 0, 6},
        '{12'hC00, 1, 6, 16, 0, 4},
        '{12'h040, 0, 2, 16, 0, 8},
        '{12'h03F, 0, 1, 31, 1, 9},
        '{12'h01F, 0, 0, 31, 0, 10}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t m;
        reset_n   = 1'b0;
        D         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        m = model(12'd127);
        check("model_127_F", m.f, 31);
        m = model(12'hFFF);
        check("model_FFF_lat", m.lat, 10);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_S", int'(S), 0);
        check("reset_E", int'(E), 0);
        check("reset_F", int'(F), 0);
        check("reset_Sixth", int'(Sixth), 0);
        check("reset_in_ready_after", int'(in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            send(vecs[i], $sformatf("vec%0d", i));
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), int'(out_valid), 0);
            check($sformatf("vec%0d_idle", i), int'(in_ready), 1);
        end

        // Backpressure on 422: outputs held, new samples refused.
        out_ready = 1'b0;
        send(vecs[5], "bp");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            D        = 12'h123;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_valid_held", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_E", int'(E), 4);
            check("bp_F", int'(F), 26);
            check("bp_Sixth", int'(Sixth), 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_after_valid", int'(out_valid), 0);
        check("bp_after_idle", int'(in_ready), 1);
        repeat (12) @(negedge clk);
        check("bp_queue_drained", exp_q.size(), 0);

        // Reset during SHIFT of 12'h001 discards the partial result.
        @(posedge clk); #1;
        D        = 12'h001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_S", int'(S), 0);
        check("rst_mid_E", int'(E), 0);
        check("rst_mid_F", int'(F), 0);
        check("rst_mid_Sixth", int'(Sixth), 0);
        check("rst_mid_in_ready_after", int'(in_ready), 1);
        send(vecs[3], "post_rst");
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_pulse", int'(out_valid), 0);
        repeat (12) @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule
